level_session_ctrl: RTL and testbench

- Session controller for the memory-tester level table.
- Owns a per-user level table with 2**ID_W entries of LEVEL_W bits.
- Sequences each session: login fetch, win-driven level-up, round start toward the RNG, and logout write-back.
- Sits between the authentication front-end and the game/RNG datapath; drives the displayed level_num.

---
 rtl/level_session_ctrl_if.sv | 34 +++
 rtl/level_session_ctrl.sv | 168 ++++++++++++++++
 tb/tb_level_session_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/level_session_ctrl_if.sv
// ============================================================================
// Module   : level_session_ctrl_if
// Purpose  : Auth/game-side signal bundle for the level session controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface level_session_ctrl_if #(
    parameter int ID_W    = 3,
    parameter int LEVEL_W = 4
);
    logic               auth_bit;
    logic [ID_W-1:0]    internal_id;
    logic               green_user;
    logic               win;
    logic               rng_button;
    logic               log_out;
    logic [LEVEL_W-1:0] level_num;
    logic               levelupdated;
    logic               round_start;
    logic               session_active;

    modport slave (
        input  auth_bit, internal_id, green_user, win, rng_button, log_out,
        output level_num, levelupdated, round_start, session_active
    );

    modport master (
        output auth_bit, internal_id, green_user, win, rng_button, log_out,
        input  level_num, levelupdated, round_start, session_active
    );
endinterface

`default_nettype wire

// File: rtl/level_session_ctrl.sv
// ============================================================================
// Module   : level_session_ctrl
// Purpose  : Per-user level table and session sequencer (login, level-up,
//            round start, logout write-back). Optional macro: LEVEL_WRAP_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module level_session_ctrl #(
    parameter int ID_W        = 3,
    parameter int LEVEL_W     = 4,
    parameter int MAX_LEVEL   = 15,
    parameter int START_LEVEL = 1
) (
    input  logic                  clock,
    input  logic                  rst,
    level_session_ctrl_if.slave   s_bus
);
    localparam int                 c_DEPTH = 2**ID_W;
    localparam logic [LEVEL_W-1:0] c_MAX   = LEVEL_W'(MAX_LEVEL);
    localparam logic [LEVEL_W-1:0] c_START = LEVEL_W'(START_LEVEL);
    localparam logic [LEVEL_W-1:0] c_ONE   = LEVEL_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_READY  = 3'd2,
        ST_UPDATE = 3'd3,
        ST_SAVE   = 3'd4
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [ID_W-1:0]    r_id, w_id_nxt;
    logic               r_green, w_green_nxt;
    logic [LEVEL_W-1:0] r_cur, w_cur_nxt;
    logic [LEVEL_W-1:0] r_table [c_DEPTH];
    logic               r_win_q, r_rng_q, r_logout_q;
    logic [LEVEL_W-1:0] r_level_num, w_level_nxt;
    logic               r_lu, w_lu_nxt;
    logic               r_rs, w_rs_nxt;
    logic               r_sa, w_sa_nxt;
    logic               w_we;
    logic [LEVEL_W-1:0] w_wdata;
    logic [LEVEL_W-1:0] w_tbl_rd;
    logic               w_win_ev, w_rng_ev, w_logout_ev;

    assign w_win_ev    = s_bus.win        & ~r_win_q;
    assign w_rng_ev    = s_bus.rng_button & ~r_rng_q;
    assign w_logout_ev = s_bus.log_out    & ~r_logout_q;
    assign w_tbl_rd    = r_table[r_id];

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_id        <= '0;
            r_green     <= 1'b0;
            r_cur       <= '0;
            r_win_q     <= 1'b0;
            r_rng_q     <= 1'b0;
            r_logout_q  <= 1'b0;
            r_level_num <= '0;
            r_lu        <= 1'b0;
            r_rs        <= 1'b0;
            r_sa        <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_id        <= w_id_nxt;
            r_green     <= w_green_nxt;
            r_cur       <= w_cur_nxt;
            r_win_q     <= s_bus.win;
            r_rng_q     <= s_bus.rng_button;
            r_logout_q  <= s_bus.log_out;
            r_level_num <= w_level_nxt;
            r_lu        <= w_lu_nxt;
            r_rs        <= w_rs_nxt;
            r_sa        <= w_sa_nxt;
        end
    end

    // Reset wipes the whole table, so an aborted session never persists.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < c_DEPTH; i++) begin
                r_table[i] <= '0;
            end
        end else if (w_we) begin
            r_table[r_id] <= w_wdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_id;
        w_green_nxt = r_green;
        w_cur_nxt   = r_cur;
        w_we        = 1'b0;
        w_wdata     = r_cur;
        w_lu_nxt    = 1'b0;
        w_rs_nxt    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (s_bus.auth_bit) begin
                    w_id_nxt    = s_bus.internal_id;
                    w_green_nxt = s_bus.green_user;
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_tbl_rd == '0) begin
                    w_cur_nxt = c_START;
                    w_we      = r_green;
                    w_wdata   = c_START;
                end else begin
                    w_cur_nxt = w_tbl_rd;
                end
                w_lu_nxt    = 1'b1;
                w_state_nxt = ST_READY;
            end
            ST_READY: begin
                if (w_logout_ev || !s_bus.auth_bit) begin
                    w_state_nxt = ST_SAVE;
                end else if (w_win_ev) begin
                    w_state_nxt = ST_UPDATE;
                end else if (w_rng_ev) begin
                    w_rs_nxt = 1'b1;
                end
            end
            ST_UPDATE: begin
                if (r_cur < c_MAX) begin
                    w_cur_nxt = r_cur + c_ONE;
                    w_lu_nxt  = 1'b1;
                    w_we      = r_green;
                    w_wdata   = r_cur + c_ONE;
                end else begin
`ifdef LEVEL_WRAP_EN
                    w_cur_nxt = c_START;
                    w_lu_nxt  = 1'b1;
                    w_we      = r_green;
                    w_wdata   = c_START;
`else
                    w_cur_nxt = r_cur;
`endif
                end
                w_state_nxt = ST_READY;
            end
            ST_SAVE: begin
                w_we        = r_green;
                w_wdata     = r_cur;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Displayed level tracks the session only while it is live.
        w_sa_nxt    = (w_state_nxt == ST_READY) || (w_state_nxt == ST_UPDATE);
        w_level_nxt = w_sa_nxt ? w_cur_nxt : '0;
    end

    assign s_bus.level_num      = r_level_num;
    assign s_bus.levelupdated   = r_lu;
    assign s_bus.round_start    = r_rs;
    assign s_bus.session_active = r_sa;
endmodule

`default_nettype wire

// File: tb/tb_level_session_ctrl.sv
// ============================================================================
// Module   : tb_level_session_ctrl
// Purpose  : Directed self-checking bench for level_session_ctrl.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_level_session_ctrl;
    localparam int ID_W    = 3;
    localparam int LEVEL_W = 4;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;
    int   lu;
    int   lu_cnt;

    always #5 clk = ~clk;

    level_session_ctrl_if #(.ID_W(ID_W), .LEVEL_W(LEVEL_W)) bus ();

    level_session_ctrl #(
        .ID_W(ID_W), .LEVEL_W(LEVEL_W), .MAX_LEVEL(15), .START_LEVEL(1)
    ) dut (
        .clock (clk),
        .rst   (rst),
        .s_bus (bus)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_login(input int id, input logic g);
        bus.auth_bit    = 1'b1;
        bus.internal_id = ID_W'(id);
        bus.green_user  = g;
        step();
        step();
    endtask

    task automatic do_logout();
        bus.log_out = 1'b1;
        step();
        bus.log_out  = 1'b0;
        bus.auth_bit = 1'b0;
        step();
        step();
    endtask

    task automatic win_pulse(output int lu_o);
        bus.win = 1'b1;
        step();
        bus.win = 1'b0;
        step();
        lu_o = int'(bus.levelupdated);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst             = 1'b1;
        bus.auth_bit    = 1'b0;
        bus.internal_id = '0;
        bus.green_user  = 1'b0;
        bus.win         = 1'b0;
        bus.rng_button  = 1'b0;
        bus.log_out     = 1'b0;
        step();
        step();
        check("rst_level", int'(bus.level_num), 0);
        check("rst_lu", int'(bus.levelupdated), 0);
        check("rst_rs", int'(bus.round_start), 0);
        check("rst_sa", int'(bus.session_active), 0);
        rst = 1'b0;

        // Fresh green login of id 1
        bus.auth_bit = 1'b1; bus.internal_id = 3'd1; bus.green_user = 1'b1;
        step();
        check("load_level", int'(bus.level_num), 0);
        step();
        check("login_level", int'(bus.level_num), 1);
        check("login_lu", int'(bus.levelupdated), 1);
        check("login_sa", int'(bus.session_active), 1);
        check("login_tbl1", int'(dut.r_table[1]), 1);
        step();
        check("login_lu_drop", int'(bus.levelupdated), 0);

        win_pulse(lu);
        check("win1_level", int'(bus.level_num), 2);
        check("win1_lu", lu, 1);
        step();
        check("win1_lu_drop", int'(bus.levelupdated), 0);
        win_pulse(lu);
        check("win2_level", int'(bus.level_num), 3);
        check("win2_lu", lu, 1);
        check("win2_tbl1", int'(dut.r_table[1]), 3);

        // Round start pulses once for a held button
        bus.rng_button = 1'b1;
        step();
        check("rs_pulse", int'(bus.round_start), 1);
        step();
        check("rs_drop", int'(bus.round_start), 0);
        bus.rng_button = 1'b0;
        step();

        // Logout beats win on the same edge
        bus.log_out = 1'b1; bus.win = 1'b1;
        step();
        check("prio_level", int'(bus.level_num), 0);
        check("prio_sa", int'(bus.session_active), 0);
        bus.auth_bit = 1'b0; bus.log_out = 1'b0; bus.win = 1'b0;
        step();
        step();
        check("prio_tbl1", int'(dut.r_table[1]), 3);

        do_login(1, 1'b1);
        check("relogin_level", int'(bus.level_num), 3);
        check("relogin_lu", int'(bus.levelupdated), 1);

        // Guest session on id 1 never touches the table
        do_logout();
        do_login(1, 1'b0);
        check("guest_login", int'(bus.level_num), 3);
        win_pulse(lu);
        win_pulse(lu);
        check("guest_level", int'(bus.level_num), 5);
        check("guest_tbl1", int'(dut.r_table[1]), 3);

        lu_cnt = 0;
        bus.win = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            lu_cnt += int'(bus.levelupdated);
        end
        bus.win = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            lu_cnt += int'(bus.levelupdated);
        end
        check("hold_level", int'(bus.level_num), 6);
        check("hold_lu_cnt", lu_cnt, 1);

        bus.green_user = 1'b1;
        bus.internal_id = 3'd4;
        win_pulse(lu);
        check("toggle_level", int'(bus.level_num), 7);
        check("toggle_tbl1", int'(dut.r_table[1]), 3);
        check("toggle_tbl4", int'(dut.r_table[4]), 0);

        // Auth drop aborts through SAVE
        bus.auth_bit = 1'b0;
        step();
        step();
        check("abort_level", int'(bus.level_num), 0);
        check("abort_sa", int'(bus.session_active), 0);
        do_login(1, 1'b1);
        check("persist_level", int'(bus.level_num), 3);
        win_pulse(lu);
        bus.auth_bit = 1'b0;
        step();
        step();
        check("abort_green_tbl1", int'(dut.r_table[1]), 4);
        do_login(1, 1'b1);
        check("abort_relogin", int'(bus.level_num), 4);

        // Climb id 2 to the ceiling
        do_logout();
        do_login(2, 1'b1);
        check("id2_login", int'(bus.level_num), 1);
        lu_cnt = 0;
        for (int i = 0; i < 14; i++) begin
            win_pulse(lu);
            lu_cnt += lu;
        end
        check("climb_level", int'(bus.level_num), 15);
        check("climb_lu_cnt", lu_cnt, 14);
        check("climb_tbl2", int'(dut.r_table[2]), 15);
        win_pulse(lu);
`ifdef LEVEL_WRAP_EN
        check("top_level", int'(bus.level_num), 1);
        check("top_lu", lu, 1);
        check("top_tbl2", int'(dut.r_table[2]), 1);
`else
        check("top_level", int'(bus.level_num), 15);
        check("top_lu", lu, 0);
        check("top_tbl2", int'(dut.r_table[2]), 15);
`endif

        // Reset while in UPDATE
        bus.win = 1'b1;
        step();
        rst = 1'b1; bus.win = 1'b0;
        step();
        check("rstupd_level", int'(bus.level_num), 0);
        check("rstupd_lu", int'(bus.levelupdated), 0);
        check("rstupd_rs", int'(bus.round_start), 0);
        check("rstupd_sa", int'(bus.session_active), 0);
        check("rstupd_tbl1", int'(dut.r_table[1]), 0);
        check("rstupd_tbl2", int'(dut.r_table[2]), 0);
        rst = 1'b0;
        bus.auth_bit = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
